// File: rtl/rect_sum_loader.sv
// rect_sum_loader: fetches the A/B/C/D corners of each rectangle and emits D-B-C+A.
// Define RECT_WEIGHT_EN to build the signed weighted feature accumulator.
module rect_sum_loader #(
    parameter int DATA_W    = 32,
    parameter int X_W       = 9,
    parameter int Y_W       = 9,
    parameter int MAX_RECTS = 3,
    parameter int RC_W      = $clog2(MAX_RECTS + 1),
    parameter int WEIGHT_W  = 8,
    parameter int ACC_W     = DATA_W + WEIGHT_W + RC_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          ready,
    input  logic [RC_W-1:0]               num_rects,
    input  logic [MAX_RECTS*X_W-1:0]      rect_x,
    input  logic [MAX_RECTS*Y_W-1:0]      rect_y,
    input  logic [MAX_RECTS*X_W-1:0]      rect_w,
    input  logic [MAX_RECTS*Y_W-1:0]      rect_h,
    input  logic [MAX_RECTS*WEIGHT_W-1:0] rect_weight,
    output logic                          rd_req,
    output logic [X_W-1:0]                rd_x,
    output logic [Y_W-1:0]                rd_y,
    input  logic                          rd_gnt,
    input  logic                          rd_valid,
    input  logic [DATA_W-1:0]             rd_data,
    output logic                          sum_valid,
    output logic [DATA_W-1:0]             sum_data,
    output logic [RC_W-1:0]               sum_idx,
    output logic                          sum_err,
    input  logic                          sum_ready,
    output logic                          feat_valid,
    output logic [ACC_W-1:0]              feat_sum
);

    typedef enum logic [2:0] {
        S_RESET,
        S_READY,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [RC_W-1:0]            nrect_q, nrect_d;
    logic [RC_W-1:0]            idx_q, idx_d;
    logic [MAX_RECTS*X_W-1:0]   rx_q, rx_d;
    logic [MAX_RECTS*Y_W-1:0]   ry_q, ry_d;
    logic [MAX_RECTS*X_W-1:0]   rw_q, rw_d;
    logic [MAX_RECTS*Y_W-1:0]   rh_q, rh_d;
    logic [X_W-1:0]             cx0_q, cx0_d;
    logic [X_W-1:0]             cx1_q, cx1_d;
    logic [Y_W-1:0]             cy0_q, cy0_d;
    logic [Y_W-1:0]             cy1_q, cy1_d;
    logic                       err_q, err_d;
    logic [2:0]                 iss_q, iss_d;
    logic [2:0]                 rsp_q, rsp_d;
    logic [DATA_W-1:0]          acc_q, acc_d;
    logic [ACC_W-1:0]           fsum_q, fsum_d;

    logic [RC_W-1:0]            n_clamp;
    logic [X_W-1:0]             cur_x;
    logic [X_W-1:0]             cur_w;
    logic [Y_W-1:0]             cur_y;
    logic [Y_W-1:0]             cur_h;
    logic [X_W:0]               xw;
    logic [Y_W:0]               yh;
    logic                       rsp_acc;
    logic                       gnt_acc;
    logic                       last_rect;

    assign n_clamp = (num_rects > RC_W'(MAX_RECTS)) ? RC_W'(MAX_RECTS) : num_rects;

    assign cur_x = rx_q[int'(idx_q)*X_W +: X_W];
    assign cur_w = rw_q[int'(idx_q)*X_W +: X_W];
    assign cur_y = ry_q[int'(idx_q)*Y_W +: Y_W];
    assign cur_h = rh_q[int'(idx_q)*Y_W +: Y_W];

    // One extra bit so a far corner past the image edge shows up as carry-out
    assign xw = {1'b0, cur_x} + {1'b0, cur_w};
    assign yh = {1'b0, cur_y} + {1'b0, cur_h};

    assign rsp_acc = rd_valid && (rsp_q < iss_q) &&
                     (state_q == S_ISSUE || state_q == S_WAIT);
    assign gnt_acc = (state_q == S_ISSUE) && rd_gnt;
    assign last_rect = (idx_q + RC_W'(1)) == nrect_q;

`ifdef RECT_WEIGHT_EN
    localparam int PROD_W = DATA_W + WEIGHT_W;

    logic [MAX_RECTS*WEIGHT_W-1:0] rwt_q, rwt_d;
    logic signed [WEIGHT_W-1:0]    cur_wt;
    logic signed [PROD_W-1:0]      prod;
    logic [ACC_W-1:0]              prod_ext;

    assign cur_wt   = rwt_q[int'(idx_q)*WEIGHT_W +: WEIGHT_W];
    assign prod     = PROD_W'($signed(acc_q)) * PROD_W'(cur_wt);
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
`else
    logic unused_weight;

    assign unused_weight = ^rect_weight;
`endif

    always_comb begin
        state_d = state_q;
        nrect_d = nrect_q;
        idx_d   = idx_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        rw_d    = rw_q;
        rh_d    = rh_q;
        cx0_d   = cx0_q;
        cx1_d   = cx1_q;
        cy0_d   = cy0_q;
        cy1_d   = cy1_q;
        err_d   = err_q;
        iss_d   = iss_q;
        rsp_d   = rsp_q;
        acc_d   = acc_q;
        fsum_d  = fsum_q;
`ifdef RECT_WEIGHT_EN
        rwt_d   = rwt_q;
`endif

        // Responses are signed +A -B -C +D in arrival order
        if (rsp_acc) begin
            if (rsp_q == 3'd0 || rsp_q == 3'd3) begin
                acc_d = acc_q + rd_data;
            end else begin
                acc_d = acc_q - rd_data;
            end
            rsp_d = rsp_q + 3'd1;
        end
        if (gnt_acc) begin
            iss_d = iss_q + 3'd1;
        end

        case (state_q)
            S_RESET: begin
                state_d = S_READY;
            end
            S_READY: begin
                if (start) begin
                    nrect_d = n_clamp;
                    idx_d   = '0;
                    rx_d    = rect_x;
                    ry_d    = rect_y;
                    rw_d    = rect_w;
                    rh_d    = rect_h;
                    fsum_d  = '0;
`ifdef RECT_WEIGHT_EN
                    rwt_d   = rect_weight;
`endif
                    state_d = (n_clamp == '0) ? S_DONE : S_LATCH;
                end
            end
            S_LATCH: begin
                cx0_d   = cur_x;
                cx1_d   = xw[X_W-1:0];
                cy0_d   = cur_y;
                cy1_d   = yh[Y_W-1:0];
                err_d   = xw[X_W] | yh[Y_W];
                acc_d   = '0;
                iss_d   = '0;
                rsp_d   = '0;
                state_d = (xw[X_W] | yh[Y_W]) ? S_EMIT : S_ISSUE;
            end
            S_ISSUE: begin
                if (gnt_acc && iss_q == 3'd3) begin
                    state_d = (rsp_d == 3'd4) ? S_EMIT : S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_d == 3'd4) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (sum_ready) begin
`ifdef RECT_WEIGHT_EN
                    if (!err_q) begin
                        fsum_d = fsum_q + prod_ext;
                    end
`endif
                    if (last_rect) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + RC_W'(1);
                        state_d = S_LATCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_READY;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            nrect_q <= '0;
            idx_q   <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            rw_q    <= '0;
            rh_q    <= '0;
            cx0_q   <= '0;
            cx1_q   <= '0;
            cy0_q   <= '0;
            cy1_q   <= '0;
            err_q   <= 1'b0;
            iss_q   <= '0;
            rsp_q   <= '0;
            acc_q   <= '0;
            fsum_q  <= '0;
`ifdef RECT_WEIGHT_EN
            rwt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            nrect_q <= nrect_d;
            idx_q   <= idx_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            rw_q    <= rw_d;
            rh_q    <= rh_d;
            cx0_q   <= cx0_d;
            cx1_q   <= cx1_d;
            cy0_q   <= cy0_d;
            cy1_q   <= cy1_d;
            err_q   <= err_d;
            iss_q   <= iss_d;
            rsp_q   <= rsp_d;
            acc_q   <= acc_d;
            fsum_q  <= fsum_d;
`ifdef RECT_WEIGHT_EN
            rwt_q   <= rwt_d;
`endif
        end
    end

    always_comb begin
        rd_x = cx0_q;
        rd_y = cy0_q;
        case (iss_q)
            3'd1: rd_x = cx1_q;
            3'd2: rd_y = cy1_q;
            3'd3: begin
                rd_x = cx1_q;
                rd_y = cy1_q;
            end
            default: begin
                rd_x = cx0_q;
                rd_y = cy0_q;
            end
        endcase
    end

    assign ready      = (state_q == S_READY);
    assign rd_req     = (state_q == S_ISSUE);
    assign sum_valid  = (state_q == S_EMIT);
    assign feat_valid = (state_q == S_DONE);
    assign sum_data   = acc_q;
    assign sum_idx    = idx_q;
    assign sum_err    = err_q;
    assign feat_sum   = fsum_q;

endmodule

// File: tb/tb_rect_sum_loader.sv
// Randomized bench for rect_sum_loader: in-order cache model plus corner-sum reference.
// Honors RECT_WEIGHT_EN for the expected feature sum.
`timescale 1ns/1ps
module tb_rect_sum_loader;

    localparam int DW  = 32;
    localparam int XW  = 9;
    localparam int YW  = 9;
    localparam int MR  = 3;
    localparam int RCW = 3;
    localparam int WW  = 8;
    localparam int AW  = DW + WW + RCW;
    localparam int CMAX = 511;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              ready;
    logic [RCW-1:0]    num_rects = '0;
    logic [MR*XW-1:0]  rect_x = '0;
    logic [MR*YW-1:0]  rect_y = '0;
    logic [MR*XW-1:0]  rect_w = '0;
    logic [MR*YW-1:0]  rect_h = '0;
    logic [MR*WW-1:0]  rect_weight = '0;
    logic              rd_req;
    logic [XW-1:0]     rd_x;
    logic [YW-1:0]     rd_y;
    logic              rd_gnt = 1'b0;
    logic              rd_valid = 1'b0;
    logic [DW-1:0]     rd_data = '0;
    logic              sum_valid;
    logic [DW-1:0]     sum_data;
    logic [RCW-1:0]    sum_idx;
    logic              sum_err;
    logic              sum_ready = 1'b0;
    logic              feat_valid;
    logic [AW-1:0]     feat_sum;

    rect_sum_loader #(
        .DATA_W(DW), .X_W(XW), .Y_W(YW), .MAX_RECTS(MR),
        .RC_W(RCW), .WEIGHT_W(WW), .ACC_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .num_rects(num_rects), .rect_x(rect_x), .rect_y(rect_y),
        .rect_w(rect_w), .rect_h(rect_h), .rect_weight(rect_weight),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .sum_valid(sum_valid), .sum_data(sum_data), .sum_idx(sum_idx),
        .sum_err(sum_err), .sum_ready(sum_ready),
        .feat_valid(feat_valid), .feat_sum(feat_sum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] d;
        int            idx;
        logic          err;
    } sum_t;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } rsp_t;

    int tests = 0;
    int fails = 0;
    int nsum = 0;
    int nrd = 0;

    logic [XW+YW-1:0] exp_rd[$];
    sum_t             exp_sum[$];
    longint           exp_feat[$];
    rsp_t             pend[$];
    logic [DW-1:0]    memo[int];

    int gnt_mode = 0;
    int sr_mode = 0;
    int lat_lo = 2;
    int lat_hi = 2;
    bit stray_en = 1'b1;

    int f_n;
    int f_x[MR];
    int f_y[MR];
    int f_w[MR];
    int f_h[MR];
    int f_wt[MR];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic miss(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: event with no expectation or timeout (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [DW-1:0] mem_rd(input int x, input int y);
        int key;
        key = x * 512 + y;
        if (memo.exists(key)) return memo[key];
        return (DW'(x) * 32'h9E3779B1) ^ (DW'(y) * 32'h85EBCA6B) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [DW-1:0] rect_sum(input int x, input int y, input int w, input int h);
        return mem_rd(x + w, y + h) - mem_rd(x + w, y) - mem_rd(x, y + h) + mem_rd(x, y);
    endfunction

    function automatic logic [XW+YW-1:0] pt(input int x, input int y);
        return {XW'(x), YW'(y)};
    endfunction

    // Reference: what the loader must produce for the feature currently in f_*
    task automatic model_push();
        int nn;
        longint fs;
        logic signed [DW-1:0] s;
        nn = (f_n > MR) ? MR : f_n;
        fs = 0;
        for (int i = 0; i < nn; i++) begin
            if (f_x[i] + f_w[i] > CMAX || f_y[i] + f_h[i] > CMAX) begin
                exp_sum.push_back('{'0, i, 1'b1});
            end else begin
                exp_rd.push_back(pt(f_x[i], f_y[i]));
                exp_rd.push_back(pt(f_x[i] + f_w[i], f_y[i]));
                exp_rd.push_back(pt(f_x[i], f_y[i] + f_h[i]));
                exp_rd.push_back(pt(f_x[i] + f_w[i], f_y[i] + f_h[i]));
                s = rect_sum(f_x[i], f_y[i], f_w[i], f_h[i]);
                exp_sum.push_back('{s, i, 1'b0});
`ifdef RECT_WEIGHT_EN
                fs += longint'(s) * longint'(f_wt[i]);
`endif
            end
        end
        exp_feat.push_back(fs);
    endtask

    task automatic flush_model();
        exp_rd.delete();
        exp_sum.delete();
        exp_feat.delete();
    endtask

    task automatic goto(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic launch(input bit use_model, output int s);
        int k;
        k = 0;
        while (!ready && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (!ready) miss("ready_wait");
        if (use_model) model_push();
        num_rects = RCW'(f_n);
        for (int i = 0; i < MR; i++) begin
            rect_x[i*XW +: XW]      = XW'(f_x[i]);
            rect_y[i*YW +: YW]      = YW'(f_y[i]);
            rect_w[i*XW +: XW]      = XW'(f_w[i]);
            rect_h[i*YW +: YW]      = YW'(f_h[i]);
            rect_weight[i*WW +: WW] = WW'(f_wt[i]);
        end
        start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_feat();
        int k;
        k = 0;
        while (exp_feat.size() > 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (exp_feat.size() > 0) begin
            miss("feat_timeout");
            flush_model();
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_checks();
        chk("rst_ready", ready, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_feat_valid", feat_valid, 0);
        chk("rst_sum_err", sum_err, 0);
        chk("rst_sum_data", sum_data, 0);
        chk("rst_sum_idx", sum_idx, 0);
        chk("rst_feat_sum", feat_sum, 0);
        chk("rst_rd_x", rd_x, 0);
        chk("rst_rd_y", rd_y, 0);
        @(negedge clk);
        chk("rst_ready_after", ready, 1);
    endtask

    task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input int wt);
        f_x[i] = x;
        f_y[i] = y;
        f_w[i] = w;
        f_h[i] = h;
        f_wt[i] = wt;
    endtask

    // In-order cache model: grants by mode, answers after a latency, injects stray valids
    initial begin
        int gp;
        gp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete();
            end else if (rd_req && rd_gnt) begin
                int due;
                due = cyc + int'($urandom_range(lat_hi, lat_lo));
                if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
                pend.push_back('{mem_rd(int'(rd_x), int'(rd_y)), due});
            end
            @(posedge clk); #1;
            case (gnt_mode)
                0: rd_gnt = 1'b1;
                1: rd_gnt = ((gp % 4) == 0) || ((gp % 4) == 3);
                default: rd_gnt = ($urandom_range(1, 0) == 1);
            endcase
            gp++;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                rd_valid = 1'b1;
                rd_data = pend[0].d;
                void'(pend.pop_front());
            end else if (stray_en && pend.size() == 0 && $urandom_range(3, 0) == 0) begin
                rd_valid = 1'b1;
                rd_data = $urandom;
            end else begin
                rd_valid = 1'b0;
                rd_data = '0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            case (sr_mode)
                0: sum_ready = 1'b1;
                1: sum_ready = ($urandom_range(1, 0) == 1);
                default: begin
                    if (!sum_valid) begin
                        cnt = 0;
                        sum_ready = 1'b0;
                    end else begin
                        sum_ready = (cnt >= 5);
                        cnt++;
                    end
                end
            endcase
        end
    end

    // Compare process: every handshake and stall cycle against the model queues
    initial begin
        bit pv, pr, pf;
        logic [DW-1:0] pd;
        logic [RCW-1:0] pi;
        logic pe;
        sum_t e;
        logic [AW-1:0] ef;
        pv = 0; pr = 0; pf = 0; pd = '0; pi = '0; pe = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 0;
                pf = 0;
                continue;
            end
            if (rd_req && rd_gnt) begin
                nrd++;
                if (exp_rd.size() == 0) miss("rd_extra");
                else chk("rd_corner", {rd_x, rd_y}, exp_rd.pop_front());
            end
            if (pv && !pr) begin
                chk("stall_stable", {sum_valid, sum_data, sum_idx, sum_err}, {1'b1, pd, pi, pe});
            end
            if (sum_valid && sum_ready) begin
                nsum++;
                if (exp_sum.size() == 0) begin
                    miss("sum_extra");
                end else begin
                    e = exp_sum.pop_front();
                    chk("sum_data", sum_data, e.d);
                    chk("sum_idx", sum_idx, RCW'(e.idx));
                    chk("sum_err", sum_err, e.err);
                end
            end
            if (pf) chk("ready_after_feat", ready, 1);
            if (feat_valid) begin
                if (exp_feat.size() == 0) begin
                    miss("feat_extra");
                end else begin
                    ef = AW'(exp_feat.pop_front());
                    chk("feat_sum", feat_sum, ef);
                    chk("feat_drained", exp_sum.size() + exp_rd.size(), 0);
                end
            end
            pv = sum_valid;
            pr = sum_ready;
            pd = sum_data;
            pi = sum_idx;
            pe = sum_err;
            pf = feat_valid;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, b_sum, b_rd;
        logic [AW-1:0] lit;
        for (int i = 0; i < MR; i++) set_rect(i, 0, 0, 0, 0, 0);
        memo[2*512+3] = 10;
        memo[6*512+3] = 30;
        memo[2*512+8] = 50;
        memo[6*512+8] = 100;
        memo[20*512+20] = 1;
        memo[21*512+20] = 2;
        memo[20*512+21] = 3;
        memo[21*512+21] = 11;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        reset_checks();
        @(posedge clk); #1;

        // Single rectangle with literal corners, pinned timing at L=2
        f_n = 1;
        set_rect(0, 2, 3, 4, 5, 1);
        exp_rd.push_back(pt(2, 3));
        exp_rd.push_back(pt(6, 3));
        exp_rd.push_back(pt(2, 8));
        exp_rd.push_back(pt(6, 8));
        exp_sum.push_back('{32'd30, 0, 1'b0});
`ifdef RECT_WEIGHT_EN
        exp_feat.push_back(30);
`else
        exp_feat.push_back(0);
`endif
        launch(0, s);
        for (int k = 1; k <= 10; k++) begin
            goto(s + k);
            chk("t1_rd_req", rd_req, (k >= 2 && k <= 5));
            chk("t1_sum_valid", sum_valid, (k == 8));
            chk("t1_feat_valid", feat_valid, (k == 9));
            chk("t1_ready", ready, (k == 10));
        end
        @(posedge clk); #1;
        wait_feat();

        // Weighted three-rectangle feature, literal expectations
        chk("pin_sum0", rect_sum(2, 3, 4, 5), 30);
        chk("pin_sum1", rect_sum(20, 20, 1, 1), 7);
        chk("pin_sum2", rect_sum(40, 40, 0, 3), 0);
        f_n = 3;
        set_rect(0, 2, 3, 4, 5, -1);
        set_rect(1, 20, 20, 1, 1, 2);
        set_rect(2, 40, 40, 0, 3, 2);
        exp_rd.push_back(pt(2, 3));
        exp_rd.push_back(pt(6, 3));
        exp_rd.push_back(pt(2, 8));
        exp_rd.push_back(pt(6, 8));
        exp_rd.push_back(pt(20, 20));
        exp_rd.push_back(pt(21, 20));
        exp_rd.push_back(pt(20, 21));
        exp_rd.push_back(pt(21, 21));
        exp_rd.push_back(pt(40, 40));
        exp_rd.push_back(pt(40, 40));
        exp_rd.push_back(pt(40, 43));
        exp_rd.push_back(pt(40, 43));
        exp_sum.push_back('{32'd30, 0, 1'b0});
        exp_sum.push_back('{32'd7, 1, 1'b0});
        exp_sum.push_back('{32'd0, 2, 1'b0});
`ifdef RECT_WEIGHT_EN
        exp_feat.push_back(-16);
`else
        exp_feat.push_back(0);
`endif
        launch(0, s);
        wait_feat();

        // Coordinate overflow on the first rectangle; stray start mid-feature
        f_n = 3;
        set_rect(0, 500, 10, 20, 5, 3);
        set_rect(1, 5, 5, 3, 3, -2);
        set_rect(2, 100, 200, 10, 10, 1);
        b_rd = nrd;
        launch(1, s);
        @(posedge clk); #1;
        @(posedge clk); #1;
        num_rects = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_feat();
        chk("ovf_reads", nrd - b_rd, 8);

        // Toggling grant and a five-cycle consumer stall
        gnt_mode = 1;
        sr_mode = 2;
        lat_lo = 1;
        lat_hi = 3;
        f_n = 3;
        set_rect(0, 7, 9, 11, 13, 5);
        set_rect(1, 300, 400, 0, 50, -7);
        set_rect(2, 450, 60, 61, 2, 9);
        b_rd = nrd;
        launch(1, s);
        wait_feat();
        chk("stall_reads", nrd - b_rd, 12);

        // Reset while two responses are outstanding
        gnt_mode = 0;
        sr_mode = 0;
        lat_lo = 6;
        lat_hi = 6;
        f_n = 1;
        set_rect(0, 10, 10, 5, 5, 1);
        launch(1, s);
        goto(s + 9);
        @(posedge clk); #1;
        rst = 1'b1;
        flush_model();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        reset_checks();
        @(posedge clk); #1;
        lat_lo = 2;
        lat_hi = 2;
        f_n = 2;
        set_rect(0, 10, 10, 5, 5, 4);
        set_rect(1, 33, 44, 55, 66, -3);
        launch(1, s);
        wait_feat();

        // Empty feature, then an over-range count
        f_n = 0;
        exp_feat.push_back(0);
        launch(0, s);
        goto(s + 1);
        chk("n0_feat_valid", feat_valid, 1);
        lit = '0;
        chk("n0_feat_sum", feat_sum, lit);
        chk("n0_no_rd", rd_req, 0);
        goto(s + 2);
        chk("n0_ready", ready, 1);
        @(posedge clk); #1;
        wait_feat();
        f_n = 7;
        set_rect(0, 1, 2, 3, 4, 1);
        set_rect(1, 5, 6, 7, 8, 1);
        set_rect(2, 9, 10, 11, 12, 1);
        b_sum = nsum;
        launch(1, s);
        wait_feat();
        chk("n7_sums", nsum - b_sum, 3);

        // Randomized features
        for (int t = 0; t < 40; t++) begin
            gnt_mode = $urandom_range(2, 0);
            sr_mode = $urandom_range(1, 0);
            lat_lo = 1;
            lat_hi = $urandom_range(4, 1);
            f_n = $urandom_range(7, 0);
            for (int i = 0; i < MR; i++) begin
                set_rect(i, $urandom_range(511, 300), $urandom_range(511, 0),
                         $urandom_range(40, 0), $urandom_range(40, 0),
                         int'($urandom_range(255, 0)) - 128);
            end
            launch(1, s);
            wait_feat();
        end

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rect_sum_loader.md
# rect_sum_loader

Parametrised successor to the single-rectangle A/B/C/D variable loader. For each feature it fetches the four corner values of up to MAX_RECTS rectangles from the integral image cache over an in-order request/response port. It then emits one rectangle sum D − B − C + A per rectangle to the classifier core. It sits between the feature-descriptor sequencer and the integral image cache read port.

## Interface
Parameters:
- DATA_W, 32: integral image word width.
- X_W, 9: column coordinate width.
- Y_W, 9: row coordinate width.
- MAX_RECTS, 3: maximum rectangles per feature.
- RC_W, clog2(MAX_RECTS+1): rectangle count/index width.
- WEIGHT_W, 8: signed rectangle weight width.
- ACC_W, DATA_W+WEIGHT_W+RC_W: feature accumulator width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  feature request pulse; accepted only while ready=1.
- ready  out  1  idle and able to accept start.
- num_rects  in  RC_W  rectangles in this feature; sampled with start.
- rect_x, rect_y  in  MAX_RECTS*X_W / MAX_RECTS*Y_W  top-left corner per rectangle; slot i at [i*W +: W]; sampled with start.
- rect_w, rect_h  in  MAX_RECTS*X_W / MAX_RECTS*Y_W  width and height per rectangle; sampled with start.
- rect_weight  in  MAX_RECTS*WEIGHT_W  signed weight per rectangle; sampled with start.
- rd_req  out  1  corner read request.
- rd_x, rd_y  out  X_W / Y_W  corner coordinate.
- rd_gnt  in  1  request accepted when rd_req && rd_gnt.
- rd_valid, rd_data  in  1 / DATA_W  read response; strictly in request order.
- sum_valid  out  1  rectangle sum available.
- sum_data  out  DATA_W  rectangle sum.
- sum_idx  out  RC_W  rectangle index.
- sum_err  out  1  coordinate overflow flag for this rectangle.
- sum_ready  in  1  consumer takes sum when sum_valid && sum_ready.
- feat_valid  out  1  one-cycle pulse at the end of each feature.
- feat_sum  out  ACC_W  weighted feature sum.

## Operation
- States: S_Reset → S_Ready → S_Latch → S_Issue → S_Wait → S_Emit → (S_Latch for the next rectangle | S_Done) → S_Ready.
- S_Reset lasts one cycle after rst deasserts.
- start in S_Ready latches all inputs. num_rects is clamped to MAX_RECTS.
- num_rects=0: go directly to S_Done. No reads are issued and feat_sum=0.
- S_Latch computes corners, in this issue order:
  - A=(x, y)
  - B=(x+w, y)
  - C=(x, y+h)
  - D=(x+w, y+h)
- x+w and y+h are computed one bit wider than the coordinate. On carry-out, sum_err=1, no reads are issued, and the state goes to S_Emit with sum_data=0.
- S_Issue holds rd_req=1 and advances to the next corner only on rd_gnt. After the 4th grant it moves to S_Wait, or directly to S_Emit if all 4 responses have already arrived.
- Responses may arrive during S_Issue. A 3-bit response counter applies the signs +A, −B, −C, +D in order.
- Arithmetic is modulo 2^DATA_W. w=0 or h=0 yields 0 naturally.
- rd_valid is ignored when no response is outstanding, and in S_Ready, S_Emit and S_Done.
- S_Emit holds sum_valid, sum_data, sum_idx and sum_err stable until sum_ready.
- Rectangles are processed strictly serially; the next rectangle's reads never overlap the current emit.
- start while not ready is ignored.

## Timing
- Reset values:
  - ready=0 in S_Reset, then 1.
  - rd_req, sum_valid, feat_valid, sum_err = 0.
  - sum_data, sum_idx, feat_sum, rd_x, rd_y = 0.
- rst mid-operation aborts on the next edge. Outstanding responses are discarded; the cache is reset concurrently.
- With rd_gnt=1 and response latency L: rd_req is high in cycles start+2 through start+5. sum_valid rises one cycle after the 4th rd_valid.
- sum_valid && sum_ready in cycle T: the next rectangle's first rd_req is at T+2. After the last rectangle, feat_valid pulses at T+1.
- ready returns the cycle after feat_valid. A new start is accepted in that cycle.

## Configuration
- RECT_WEIGHT_EN defined:
  - Each rectangle sum is multiplied by its signed rect_weight.
  - The product is sign-extended and accumulated into feat_sum.
  - Rectangles with sum_err contribute 0.
- RECT_WEIGHT_EN undefined:
  - No multiplier is built.
  - rect_weight is ignored and feat_sum is held at 0.
  - feat_valid still pulses.

## Test plan
- Reset, then stimulus num_rects=1, rect (2,3,4,5), rd_gnt=1, L=2, corner data A=10, B=30, C=50, D=100 -> sum_data=30, sum_idx=0, sum_err=0, rd_req high at start+2 through start+5.
- num_rects=3, weights −1, 2, 2 with sums 30, 7, 0 under RECT_WEIGHT_EN -> feat_sum=−16, one feat_valid pulse after the 3rd sum handshake. Same run without the macro -> feat_sum=0.
- rect_x=500, rect_w=20 with X_W=9 -> sum_err=1, sum_data=0, no rd_req for that rectangle, later rectangles unaffected.
- rd_gnt toggling 1,0,0,1,… and sum_ready held low 5 cycles -> corners issued A, B, C, D exactly once each, and outputs stable during the stall.
- rst asserted mid-S_Wait with 2 responses outstanding -> all outputs at reset values next cycle, stray rd_valid ignored, next feature correct.
- num_rects=0 and num_rects=7 (MAX_RECTS=3) -> immediate feat_valid with feat_sum=0, and 3 rectangles processed, respectively.
